// File: rtl/tron_pkg.sv
// ---------------------------------------------------------------------------
// tron_pkg
// Shared definitions for the light-cycle game: the game-state encoding driven
// by the game state machine, the scorer's internal FSM states, default game
// parameters and a saturating score increment helper.
// ---------------------------------------------------------------------------
package tron_pkg;

    // Encoding of the Game_State bus produced by the game state machine.
    typedef enum logic [2:0] {
        GS_MENU          = 3'd0,
        GS_ROUND_PAUSED  = 3'd1,
        GS_ROUND_STARTED = 3'd2,
        GS_BLUE_WINS     = 3'd3,
        GS_RED_WINS      = 3'd4
    } game_state_e;

    // Round wins needed to take the game.
    localparam int WIN_SCORE_DEFAULT   = 3;

    // Frames the arena stays frozen after a crash.
    localparam int HOLD_FRAMES_DEFAULT = 60;

    // Round scorer states.
    typedef enum logic [1:0] {
        SC_IDLE,
        SC_PLAY,
        SC_HOLD,
        SC_END
    } scorer_state_e;

    // Increment a score but never pass the limit, so a score cannot wrap.
    function automatic logic [1:0] sat_inc(input logic [1:0] value,
                                           input logic [1:0] limit);
        return (value >= limit) ? value : value + 2'd1;
    endfunction

endpackage

// File: rtl/round_hold_timer.sv
// ---------------------------------------------------------------------------
// round_hold_timer
// Frame-counted down-counter used to freeze the arena after a crash.
//
// Ports:
//   clk_i        - system clock
//   rst_ni       - asynchronous active-low reset (clears the count)
//   load_i       - load HOLD_FRAMES into the counter (takes priority)
//   frame_tick_i - one-cycle pulse per video frame; decrements the count
//   done_o       - high while the count is zero
// ---------------------------------------------------------------------------
module round_hold_timer #(
    parameter int HOLD_FRAMES = 60
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic frame_tick_i,
    output logic done_o
);

    localparam logic [7:0] LOAD_VALUE = 8'(HOLD_FRAMES);

    logic [7:0] count_q;
    logic [7:0] count_d;

    // Load wins over a coincident tick; the count rests at zero rather than
    // wrapping if ticks keep arriving.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VALUE;
        end else if (frame_tick_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == 8'd0);

endmodule

// File: rtl/round_scorer.sv
// ---------------------------------------------------------------------------
// round_scorer
// Watches the two bikes during a round, awards round wins, freezes the arena
// for a number of frames after a crash, then either declares the game winner
// or asks the game state machine to start a fresh round.
//
// Ports:
//   Clk         - system clock, rising edge
//   Reset_n     - asynchronous active-low reset
//   Game_State  - current game state (see tron_pkg::game_state_e)
//   frame_tick  - one-cycle pulse per video frame
//   Blue_Crash  - blue bike hit a trail or wall this cycle
//   Red_Crash   - red bike hit a trail or wall this cycle
//   Score_B     - blue round wins
//   Score_R     - red round wins
//   Blue_W      - blue has won the game (held while the round state lasts)
//   Red_W       - red has won the game (held while the round state lasts)
//   Reset_Round - one-cycle pulse: round over, game continues
//   Freeze      - bike motion halted during the post-crash hold
// ---------------------------------------------------------------------------
module round_scorer
    import tron_pkg::*;
#(
    parameter int WIN_SCORE   = WIN_SCORE_DEFAULT,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] Game_State,
    input  logic       frame_tick,
    input  logic       Blue_Crash,
    input  logic       Red_Crash,
    output logic [1:0] Score_B,
    output logic [1:0] Score_R,
    output logic       Blue_W,
    output logic       Red_W,
    output logic       Reset_Round,
    output logic       Freeze
);

    localparam logic [1:0] WIN = 2'(WIN_SCORE);

    scorer_state_e state_q, state_d;
    logic [1:0]    score_b_q, score_b_d;
    logic [1:0]    score_r_q, score_r_d;
    logic          blue_w_q, blue_w_d;
    logic          red_w_q, red_w_d;
    logic          reset_round_q, reset_round_d;
    logic          freeze_q, freeze_d;

    logic          hold_load;
    logic          hold_done;
    logic          round_started;

    assign round_started = (Game_State == GS_ROUND_STARTED);

    round_hold_timer #(
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_hold_timer (
        .clk_i        (Clk),
        .rst_ni       (Reset_n),
        .load_i       (hold_load),
        .frame_tick_i (frame_tick),
        .done_o       (hold_done)
    );

    // Next-state and next-output logic. Leaving the round-started state
    // overrides everything: the FSM drops to IDLE, which also releases the
    // freeze and silently discards any pending round result. A declared
    // winner blocks IDLE->PLAY so no further round is scored until the game
    // state machine moves on to its win state.
    always_comb begin
        state_d       = state_q;
        score_b_d     = score_b_q;
        score_r_d     = score_r_q;
        blue_w_d      = blue_w_q & round_started;
        red_w_d       = red_w_q & round_started;
        reset_round_d = 1'b0;
        hold_load     = 1'b0;

        if (!round_started) begin
            state_d = SC_IDLE;
        end else begin
            case (state_q)
                SC_IDLE: begin
                    if (!blue_w_q && !red_w_q) begin
                        state_d = SC_PLAY;
                    end
                end
                SC_PLAY: begin
                    if (Blue_Crash || Red_Crash) begin
                        state_d   = SC_HOLD;
                        hold_load = 1'b1;
                        // A crash scores for the opponent; a double crash
                        // is a draw.
                        if (Blue_Crash && !Red_Crash) begin
                            score_r_d = sat_inc(score_r_q, WIN);
                        end else if (Red_Crash && !Blue_Crash) begin
                            score_b_d = sat_inc(score_b_q, WIN);
                        end
                    end
                end
                SC_HOLD: begin
                    if (hold_done) begin
                        state_d = SC_END;
                    end
                end
                SC_END: begin
                    state_d = SC_IDLE;
                    if (score_b_q == WIN) begin
                        blue_w_d = 1'b1;
                    end else if (score_r_q == WIN) begin
                        red_w_d = 1'b1;
                    end else begin
                        reset_round_d = 1'b1;
                    end
                end
                default: begin
                    state_d = SC_IDLE;
                end
            endcase
        end

        if (Game_State == GS_MENU) begin
            score_b_d = 2'd0;
            score_r_d = 2'd0;
        end

        freeze_d = (state_d == SC_HOLD);
    end

    // State and registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= SC_IDLE;
            score_b_q     <= 2'd0;
            score_r_q     <= 2'd0;
            blue_w_q      <= 1'b0;
            red_w_q       <= 1'b0;
            reset_round_q <= 1'b0;
            freeze_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            score_b_q     <= score_b_d;
            score_r_q     <= score_r_d;
            blue_w_q      <= blue_w_d;
            red_w_q       <= red_w_d;
            reset_round_q <= reset_round_d;
            freeze_q      <= freeze_d;
        end
    end

    assign Score_B     = score_b_q;
    assign Score_R     = score_r_q;
    assign Blue_W      = blue_w_q;
    assign Red_W       = red_w_q;
    assign Reset_Round = reset_round_q;
    assign Freeze      = freeze_q;

endmodule

// File: tb/tb_round_scorer.sv
// ---------------------------------------------------------------------------
// tb_round_scorer
// Self-checking bench for round_scorer with a short hold (4 frames) and the
// default win score of 3. Rounds are played with random frame-tick spacing
// and random crash noise during the freeze; a game-level reference model
// (scores, winner, pulses expected per round) supplies every expected value.
// ---------------------------------------------------------------------------
module tb_round_scorer;
    import tron_pkg::*;

    localparam int HF = 4;
    localparam int WS = 3;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] Game_State;
    logic       frame_tick;
    logic       Blue_Crash;
    logic       Red_Crash;
    logic [1:0] Score_B;
    logic [1:0] Score_R;
    logic       Blue_W;
    logic       Red_W;
    logic       Reset_Round;
    logic       Freeze;

    int errors = 0;
    int checks = 0;

    // Reference model: round wins per colour.
    int sbExp = 0;
    int srExp = 0;

    always #5 Clk = ~Clk;

    round_scorer #(
        .WIN_SCORE   (WS),
        .HOLD_FRAMES (HF)
    ) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Game_State  (Game_State),
        .frame_tick  (frame_tick),
        .Blue_Crash  (Blue_Crash),
        .Red_Crash   (Red_Crash),
        .Score_B     (Score_B),
        .Score_R     (Score_R),
        .Blue_W      (Blue_W),
        .Red_W       (Red_W),
        .Reset_Round (Reset_Round),
        .Freeze      (Freeze)
    );

    // Compare one observed value against the model and report a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] gs, input logic bc,
                                 input logic rc, input logic ft);
        Game_State = gs;
        Blue_Crash = bc;
        Red_Crash  = rc;
        frame_tick = ft;
    endtask

    // Advance one clock and settle just past the edge.
    task automatic stepCycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_score_b"}, Score_B, 0);
        checkOutput({tag, "_score_r"}, Score_R, 0);
        checkOutput({tag, "_blue_w"}, Blue_W, 0);
        checkOutput({tag, "_red_w"}, Red_W, 0);
        checkOutput({tag, "_reset_round"}, Reset_Round, 0);
        checkOutput({tag, "_freeze"}, Freeze, 0);
    endtask

    function automatic int satInc(input int v);
        return (v + 1 > WS) ? WS : v + 1;
    endfunction

    // Play one round. kind: 0 = blue crashes, 1 = red crashes, 2 = both.
    // abortMid leaves the round-started state part way through the hold.
    task automatic runRound(input int kind, input bit abortMid);
        int ticks;
        int cyc;
        int rrCnt;
        int k;
        bit bothSeen;
        bit bwExp;
        bit rwExp;
        logic ft;

        applyStimulus(GS_ROUND_STARTED, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();

        applyStimulus(GS_ROUND_STARTED, logic'(kind != 1), logic'(kind != 0), 1'b0);
        stepCycle();
        if (kind == 0) srExp = satInc(srExp);
        if (kind == 1) sbExp = satInc(sbExp);
        checkOutput("score_b_after_crash", Score_B, sbExp);
        checkOutput("score_r_after_crash", Score_R, srExp);
        checkOutput("freeze_on_crash", Freeze, 1);

        if (abortMid) begin
            k = $urandom_range(0, HF - 1);
            for (int i = 0; i < k; i++) begin
                applyStimulus(GS_ROUND_STARTED, 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1)), 1'b1);
                stepCycle();
            end
            applyStimulus(GS_ROUND_PAUSED, 1'b0, 1'b0, 1'b0);
            stepCycle();
            checkOutput("abort_freeze", Freeze, 0);
            rrCnt = 0;
            for (int i = 0; i < 6; i++) begin
                if (Reset_Round) rrCnt++;
                applyStimulus(GS_ROUND_PAUSED, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                stepCycle();
            end
            checkOutput("abort_reset_round", rrCnt, 0);
            checkOutput("abort_score_b", Score_B, sbExp);
            checkOutput("abort_score_r", Score_R, srExp);
            return;
        end

        ticks = 0;
        cyc   = 0;
        while (Freeze && cyc < 200) begin
            ft = logic'((ticks < HF) && ($urandom_range(0, 2) == 0));
            applyStimulus(GS_ROUND_STARTED, 1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0), ft);
            if (ft) ticks++;
            stepCycle();
            cyc++;
        end
        applyStimulus(GS_ROUND_STARTED, 1'b0, 1'b0, 1'b0);
        checkOutput("freeze_released", Freeze, 0);
        checkOutput("hold_ticks", ticks, HF);
        checkOutput("hold_score_b", Score_B, sbExp);
        checkOutput("hold_score_r", Score_R, srExp);

        rrCnt    = 0;
        bothSeen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            if (Reset_Round) rrCnt++;
            if (Blue_W && Red_W) bothSeen = 1'b1;
        end
        bwExp = (sbExp == WS);
        rwExp = !bwExp && (srExp == WS);
        checkOutput("reset_round_pulses", rrCnt, (bwExp || rwExp) ? 0 : 1);
        checkOutput("blue_w", Blue_W, bwExp);
        checkOutput("red_w", Red_W, rwExp);
        checkOutput("w_exclusive", bothSeen, 0);

        if (bwExp || rwExp) begin
            applyStimulus(bwExp ? GS_BLUE_WINS : GS_RED_WINS, 1'b0, 1'b0, 1'b0);
            stepCycle();
            checkOutput("win_clear_blue", Blue_W, 0);
            checkOutput("win_clear_red", Red_W, 0);
            applyStimulus(GS_MENU, 1'b0, 1'b0, 1'b0);
            stepCycle();
            sbExp = 0;
            srExp = 0;
            checkOutput("menu_score_b", Score_B, sbExp);
            checkOutput("menu_score_r", Score_R, srExp);
            checkOutput("menu_freeze", Freeze, 0);
        end
    endtask

    // Assert reset asynchronously in the middle of a hold.
    task automatic resetMidHold();
        applyStimulus(GS_ROUND_STARTED, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        applyStimulus(GS_ROUND_STARTED, 1'b1, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(GS_ROUND_STARTED, 1'b0, 1'b0, 1'b1);
        stepCycle();
        applyStimulus(GS_ROUND_STARTED, 1'b0, 1'b0, 1'b0);
        #2;
        Reset_n = 1'b0;
        #1;
        checkAllZero("async_reset");
        stepCycle();
        Reset_n = 1'b1;
        sbExp = 0;
        srExp = 0;
    endtask

    task automatic menuVisit();
        applyStimulus(GS_MENU, 1'b0, 1'b0, 1'b0);
        stepCycle();
        sbExp = 0;
        srExp = 0;
        checkOutput("menu_visit_score_b", Score_B, 0);
        checkOutput("menu_visit_score_r", Score_R, 0);
        checkOutput("menu_visit_freeze", Freeze, 0);
    endtask

    initial begin
        int r;
        Reset_n = 1'b0;
        applyStimulus(GS_MENU, 1'b0, 1'b0, 1'b0);
        stepCycle();
        stepCycle();
        checkAllZero("reset");
        Reset_n = 1'b1;
        stepCycle();

        // Red crash, then a draw, then blue crashes three times (red wins).
        runRound(1, 1'b0);
        runRound(2, 1'b0);
        runRound(0, 1'b0);
        runRound(0, 1'b0);
        runRound(0, 1'b0);
        runRound(1, 1'b1);
        resetMidHold();
        runRound(1, 1'b0);
        menuVisit();

        for (int ep = 0; ep < 40; ep++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      resetMidHold();
            else if (r == 1) menuVisit();
            else if (r == 2) runRound($urandom_range(0, 2), 1'b1);
            else             runRound($urandom_range(0, 2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/round_scorer.md
ROUND_SCORER -- requirements
Module: round_scorer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 3, range 1..3: round wins needed to win the game.
REQ-002 SHALL have parameter HOLD_FRAMES, default 60, range 1..255: frames frozen after a crash before the round ends.
REQ-003 SHALL have port Clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port Game_State  input  3  current game state (Menu=0, Round_Paused=1, Round_Started=2, Blue_Wins=3, Red_Wins=4).
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-007 SHALL have port Blue_Crash  input  1  level; blue bike has hit a trail or wall this cycle.
REQ-008 SHALL have port Red_Crash  input  1  level; red bike has hit a trail or wall this cycle.
REQ-009 SHALL have port Score_B  output  2  blue round wins.
REQ-010 SHALL have port Score_R  output  2  red round wins.
REQ-011 SHALL have port Blue_W  output  1  level; blue has won the game.
REQ-012 SHALL have port Red_W  output  1  level; red has won the game.
REQ-013 SHALL have port Reset_Round  output  1  one-cycle pulse; round over, game continues.
REQ-014 SHALL have port Freeze  output  1  level; bike motion halted during crash hold.

Function
REQ-015 SHALL implement FSM states IDLE, PLAY, HOLD, END; all outputs registered.
REQ-016 IDLE->PLAY SHALL occur on the first cycle Game_State==Round_Started; in any state, Game_State!=Round_Started SHALL force IDLE next cycle.
REQ-017 In PLAY, Blue_Crash only SHALL increment Score_R; Red_Crash only SHALL increment Score_B; both in the same cycle SHALL be a draw with no score change; any crash SHALL move to HOLD.
REQ-018 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-019 On entering HOLD, the hold counter SHALL load HOLD_FRAMES and Freeze SHALL assert the next cycle.
REQ-020 In HOLD, the counter SHALL decrement once per frame_tick; crash inputs SHALL be ignored; at count 0, the FSM SHALL move to END.
REQ-021 In END, if Score_B==WIN_SCORE, Blue_W SHALL assert; else if Score_R==WIN_SCORE, Red_W SHALL assert; otherwise, Reset_Round SHALL pulse for exactly one cycle. The FSM SHALL then return to IDLE and Freeze SHALL deassert.
REQ-022 Blue_W/Red_W SHALL stay asserted until Game_State!=Round_Started, then clear on the next cycle.
REQ-023 Blue_W and Red_W SHALL never be asserted together.
REQ-024 Score_B and Score_R SHALL clear to 0 on any cycle Game_State==Menu.
REQ-025 A Reset_Round pulse SHALL be emitted at most once per crash event.
REQ-026 Leaving Round_Started mid-PLAY or mid-HOLD SHALL abort without scoring further, deassert Freeze, and emit no Reset_Round.

Reset
REQ-027 Reset_n low SHALL immediately force state IDLE, counter 0, Score_B=Score_R=0, and Blue_W=Red_W=Reset_Round=Freeze=0.
REQ-028 Reset assertion mid-HOLD SHALL discard the pending round result.

Structure
REQ-029 The game-state encoding enum and the WIN_SCORE default SHALL live in shared package tron_pkg, used by both the game state machine and this block.
REQ-030 The frame-counted hold down-counter SHALL be sub-module round_hold_timer (load, frame_tick, done).

Verification
REQ-031 In Round_Started, Red_Crash pulse, HOLD_FRAMES=4 -> Score_B 0->1, Freeze high for 4 frame_ticks, then a single one-cycle Reset_Round pulse and Freeze low.
REQ-032 Blue_Crash and Red_Crash in the same cycle -> scores unchanged, hold runs, Reset_Round pulses once.
REQ-033 Score_R=2, WIN_SCORE=3, Blue_Crash -> Score_R=3, after hold Red_W=1 and no Reset_Round; Game_State->Red_Wins -> Red_W=0 next cycle.
REQ-034 Crash pulses during HOLD -> no score change; Game_State->Menu -> scores 0, FSM IDLE, Freeze 0.
REQ-035 Reset_n low mid-HOLD -> all outputs 0 asynchronously; after release with Game_State=Round_Started -> PLAY with scores 0.
